temp_threshold_monitor: RTL and testbench
=========================================

Name: temp_threshold_monitor

Overview:
- Consumes the registered 8-bit Celsius value from the Fahrenheit-to-Celsius stage and decimates it to one sample every SAMPLE_DIV clocks.
- Computes a 2^AVG_LOG2-point moving average of those samples.
- Runs a NORMAL/WARN/CRIT state machine with hysteresis and persistence filtering.
- Outputs drive the alarm/status logic downstream.

Parameters:
- SAMPLE_DIV, 5, clocks between successive captures of celsius (>=2)
- AVG_LOG2, 2, log2 of averaging window depth (window = 4 samples)
- PERSIST, 3, consecutive evaluated averages required before any state change (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- celsius  in  8  unsigned Celsius from upstream converter
- warn_thresh  in  8  WARN entry threshold, degrees C
- crit_thresh  in  8  CRIT entry threshold, degrees C
- hyst  in  8  hysteresis band subtracted for downward transitions
- sample_stb  out  1  one-cycle pulse: new average and state evaluated
- avg_c  out  8  moving-average Celsius value
- avg_valid  out  1  window filled; avg_c meaningful
- state  out  2  00 NORMAL, 01 WARN, 10 CRIT (11 unused)
- warn  out  1  state is WARN or CRIT
- crit  out  1  state is CRIT

Behaviour:
- Reset: async assert clears div counter, window, running sum, fill count, persist counter and all outputs to 0; state=NORMAL.
- Decimation:
  - div counter counts 0..SAMPLE_DIV-1 from reset release.
  - At the edge where counter==SAMPLE_DIV-1, celsius is captured and the counter wraps to 0.
  - First capture occurs at the SAMPLE_DIV-th rising edge after rstn deasserts.
- Window:
  - Circular buffer of 2^AVG_LOG2 x 8b; running sum is 8+AVG_LOG2 bits.
  - On capture: sum <= sum + new - oldest; oldest is overwritten.
  - Empty entries count as 0.
- Average timing:
  - avg_c = sum >> AVG_LOG2 (truncating), registered.
  - avg_c and sample_stb update one cycle after capture.
  - avg_valid rises with the sample_stb of the 2^AVG_LOG2-th capture and stays high until reset.
- FSM evaluation: runs only on sample_stb cycles with avg_valid=1, using the new avg_c. Down thresholds are thresh-hyst, saturating at 0 (never negative).
- Target state:
  - NORMAL: avg>=crit -> CRIT; else avg>=warn -> WARN; else NORMAL.
  - WARN: avg>=crit -> CRIT; avg<warn-hyst -> NORMAL; else WARN.
  - CRIT: avg>=crit-hyst -> CRIT; else avg<warn-hyst -> NORMAL; else WARN.
- Persistence:
  - target==state clears the counter.
  - target!=state and same as the previous target increments the counter.
  - A new differing target restarts the count at 1.
  - When the count reaches PERSIST, state <= target and the counter clears.
  - Transition becomes visible one cycle after that evaluation.
- crit_thresh<=warn_thresh: CRIT checks take priority; no error flagged.
- warn/crit are registered decodes of state, changing in the same cycle as state.
- Threshold/hyst inputs are sampled only at evaluation; changes between strobes have no effect.
- Reset mid-operation discards window contents; avg_valid must refill before any state change.

Optional Feature:
- Macro TEMP_MON_CRIT_LATCH_EN.
- Defined:
  - Adds input latch_clr (1b) and output crit_latched (1b).
  - crit_latched sets on any cycle crit=1 and holds until latch_clr=1 while crit=0; latch_clr is ignored while crit=1.
  - crit_latched resets to 0.
- Undefined: both ports and the latch logic are absent.

Test Plan (SAMPLE_DIV=5, AVG_LOG2=2, PERSIST=3, warn=70, crit=90, hyst=5):
1. Reset, celsius=37 constant -> outputs 0 during reset; sample_stb every 5 clocks; avg_valid and avg_c=37 on the 4th strobe; state stays NORMAL.
2. Captured samples 60,70,80,90 -> avg_c=75 on 4th strobe; samples 37,37,37,38 -> avg_c=37 (truncation).
3. Averages 75,75,60 -> stays NORMAL with counter cleared; then 75,75,75 -> WARN after 3rd, warn=1, crit=0.
4. In WARN, averages 66,66,66 -> stays WARN; then 64,64,64 -> NORMAL, warn=0.
5. From NORMAL, averages 95x3 -> CRIT directly, warn=crit=1; 87x3 -> stays CRIT; 80x3 -> WARN. With TEMP_MON_CRIT_LATCH_EN: crit_latched=1 until latch_clr pulse after exit.
6. rstn low mid-operation while CRIT -> all outputs 0 immediately; after release, no strobe until 5 clocks, avg_valid low until 4 new captures.

Source files
------------

// File: rtl/temp_threshold_monitor.sv
// temp_threshold_monitor: decimates the upstream Celsius value, keeps a
// 2^AVG_LOG2-point moving average, and classifies it as NORMAL/WARN/CRIT.
// The classifier uses hysteresis and persistence filtering.
// Optional feature macro: TEMP_MON_CRIT_LATCH_EN adds latch_clr/crit_latched,
// a sticky record that CRIT was reached.
module temp_threshold_monitor #(
  parameter int SAMPLE_DIV = 5,
  parameter int AVG_LOG2   = 2,
  parameter int PERSIST    = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] celsius,
  input  logic [7:0] warn_thresh,
  input  logic [7:0] crit_thresh,
  input  logic [7:0] hyst,
`ifdef TEMP_MON_CRIT_LATCH_EN
  input  logic       latch_clr,
  output logic       crit_latched,
`endif
  output logic       sample_stb,
  output logic [7:0] avg_c,
  output logic       avg_valid,
  output logic [1:0] state,
  output logic       warn,
  output logic       crit
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUMW  = 8 + AVG_LOG2;
  localparam int DIVW  = $clog2(SAMPLE_DIV);
  localparam int PTRW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILLW = AVG_LOG2 + 1;
  localparam int PCW   = $clog2(PERSIST + 1);

  localparam logic [DIVW-1:0]  DIV_LAST  = DIVW'(SAMPLE_DIV - 1);
  localparam logic [FILLW-1:0] FILL_FULL = FILLW'(DEPTH);
  localparam logic [PCW-1:0]   PERSIST_N = PCW'(PERSIST);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_WARN   = 2'b01,
    ST_CRIT   = 2'b10
  } state_e;

  // Decimation, window and averaging registers
  logic [DIVW-1:0]  div_q;
  logic             capture;
  logic             cap_q;
  logic [7:0]       win_q [DEPTH];
  logic [PTRW-1:0]  ptr_q;
  logic [SUMW-1:0]  sum_q;
  logic [SUMW-1:0]  sum_d;
  logic [FILLW-1:0] fill_q;
  logic             stb_q;
  logic [7:0]       avg_q;
  logic             valid_q;

  // Classifier registers
  state_e           state_q, state_d;
  state_e           target;
  state_e           ptgt_q, ptgt_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             warn_q, crit_q;
  logic             eval;
  logic [7:0]       warn_dn, crit_dn;

  assign capture = (div_q == DIV_LAST);
  // The entry being overwritten drops out of the running sum; empty entries are 0.
  assign sum_d   = sum_q + SUMW'(celsius) - SUMW'(win_q[ptr_q]);

  // Free-running decimation counter, wraps on the capture edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
    end else if (capture) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // One register per window slot; only the slot under the write pointer loads
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        win_q[gi] <= '0;
      end else if (capture && (ptr_q == PTRW'(gi))) begin
        win_q[gi] <= celsius;
      end
    end
  end

  // Running sum, write pointer and fill count advance once per capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      cap_q <= capture;
      if (capture) begin
        ptr_q <= (ptr_q == PTRW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        sum_q <= sum_d;
        if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  // Average and strobe are published the cycle after the capture updated the sum
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stb_q   <= 1'b0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      stb_q <= cap_q;
      if (cap_q) begin
        avg_q <= sum_q[SUMW-1:AVG_LOG2];
        if (fill_q == FILL_FULL) begin
          valid_q <= 1'b1;
        end
      end
    end
  end

  // Downward thresholds saturate at zero so a large band never wraps around
  assign warn_dn = (warn_thresh > hyst) ? (warn_thresh - hyst) : 8'd0;
  assign crit_dn = (crit_thresh > hyst) ? (crit_thresh - hyst) : 8'd0;
  assign eval    = stb_q && valid_q;

  // Target classification and persistence filter
  always_comb begin
    target  = state_q;
    state_d = state_q;
    pcnt_d  = pcnt_q;
    ptgt_d  = ptgt_q;
    case (state_q)
      ST_WARN: begin
        if (avg_q >= crit_thresh)  target = ST_CRIT;
        else if (avg_q < warn_dn)  target = ST_NORMAL;
        else                       target = ST_WARN;
      end
      ST_CRIT: begin
        if (avg_q >= crit_dn)      target = ST_CRIT;
        else if (avg_q < warn_dn)  target = ST_NORMAL;
        else                       target = ST_WARN;
      end
      default: begin
        // CRIT is tested first so it wins even when crit_thresh <= warn_thresh
        if (avg_q >= crit_thresh)       target = ST_CRIT;
        else if (avg_q >= warn_thresh)  target = ST_WARN;
        else                            target = ST_NORMAL;
      end
    endcase
    if (eval) begin
      ptgt_d = target;
      if (target == state_q) begin
        pcnt_d = '0;
      end else begin
        if ((pcnt_q != '0) && (target == ptgt_q)) pcnt_d = pcnt_q + 1'b1;
        else                                      pcnt_d = PCW'(1);
        if (pcnt_d == PERSIST_N) begin
          state_d = target;
          pcnt_d  = '0;
        end
      end
    end
  end

  // Classifier state plus registered warn/crit decodes of the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_NORMAL;
      ptgt_q  <= ST_NORMAL;
      pcnt_q  <= '0;
      warn_q  <= 1'b0;
      crit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptgt_q  <= ptgt_d;
      pcnt_q  <= pcnt_d;
      warn_q  <= (state_d == ST_WARN) || (state_d == ST_CRIT);
      crit_q  <= (state_d == ST_CRIT);
    end
  end

`ifdef TEMP_MON_CRIT_LATCH_EN
  logic latched_q;

  // Sticky CRIT record; a clear request is ignored while still in CRIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      latched_q <= 1'b0;
    end else if (crit_q) begin
      latched_q <= 1'b1;
    end else if (latch_clr) begin
      latched_q <= 1'b0;
    end
  end

  assign crit_latched = latched_q;
`endif

  assign sample_stb = stb_q;
  assign avg_c      = avg_q;
  assign avg_valid  = valid_q;
  assign state      = state_q;
  assign warn       = warn_q;
  assign crit       = crit_q;

endmodule

// File: tb/tb_temp_threshold_monitor.sv
// Bench for temp_threshold_monitor: per-sample transactions checked against a
// numeric model of the window average and the hysteresis/persistence rules.
module tb_temp_threshold_monitor;

  localparam int SAMPLE_DIV = 5;
  localparam int AVG_LOG2   = 2;
  localparam int PERSIST    = 3;
  localparam int WIN        = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] celsius = 8'd0;
  logic [7:0] warn_thresh = 8'd70;
  logic [7:0] crit_thresh = 8'd90;
  logic [7:0] hyst = 8'd5;
  logic       sample_stb, avg_valid, warn, crit;
  logic [7:0] avg_c;
  logic [1:0] state;
`ifdef TEMP_MON_CRIT_LATCH_EN
  logic       latch_clr = 1'b0;
  logic       crit_latched;
`endif

  int vectors = 0;
  int errors  = 0;

  // Model: last WIN captured samples, capture count, state, pending-change run
  int hist[$];
  int m_count;
  int m_state;
  int run_tgt;
  int run_len;
  bit m_latch;

  temp_threshold_monitor #(
    .SAMPLE_DIV(SAMPLE_DIV), .AVG_LOG2(AVG_LOG2), .PERSIST(PERSIST)
  ) dut (
    .clk(clk), .rstn(rstn), .celsius(celsius),
    .warn_thresh(warn_thresh), .crit_thresh(crit_thresh), .hyst(hyst),
`ifdef TEMP_MON_CRIT_LATCH_EN
    .latch_clr(latch_clr), .crit_latched(crit_latched),
`endif
    .sample_stb(sample_stb), .avg_c(avg_c), .avg_valid(avg_valid),
    .state(state), .warn(warn), .crit(crit)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    m_count = 0;
    m_state = 0;
    run_tgt = 0;
    run_len = 0;
    m_latch = 1'b0;
  endtask

  function automatic int window_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / WIN;
  endfunction

  function automatic int target_of(int st, int avg, int w, int c, int h);
    int wd = (w > h) ? w - h : 0;
    int cd = (c > h) ? c - h : 0;
    if (st == 2) return (avg >= cd) ? 2 : ((avg < wd) ? 0 : 1);
    if (st == 1) return (avg >= c) ? 2 : ((avg < wd) ? 0 : 1);
    return (avg >= c) ? 2 : ((avg >= w) ? 1 : 0);
  endfunction

  // One captured sample: drive it, await the strobe, check average then state.
  // exp_gap is the number of falling edges from entry to the strobe.
  task automatic apply_sample(input int v, input int exp_gap, input bit junk, input bit clr);
    int n;
    int exp_avg, tgt;
    bit exp_valid;
    logic [7:0] w0, c0, h0;
    w0 = warn_thresh; c0 = crit_thresh; h0 = hyst;
    celsius = 8'(v);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
`ifdef TEMP_MON_CRIT_LATCH_EN
      if (n == 1) begin
        vectors++;
        if (crit_latched !== m_latch) begin
          errors++;
          $display("FAIL latched_hold: got %0b want %0b", crit_latched, m_latch);
        end
        if (clr) latch_clr = 1'b1;
      end
      if (n == 2 && clr) begin
        latch_clr = 1'b0;
        @(posedge clk);
        #1;
        if (m_state != 2) m_latch = 1'b0;
        vectors++;
        if (crit_latched !== m_latch) begin
          errors++;
          $display("FAIL latched_clr: got %0b want %0b", crit_latched, m_latch);
        end
        @(negedge clk);
        n++;
      end
`else
      if (clr && n == 1) vectors = vectors;
`endif
      if (junk && n == 1) begin
        warn_thresh = 8'($urandom_range(0, 255));
        crit_thresh = 8'($urandom_range(0, 255));
        hyst        = 8'($urandom_range(0, 255));
      end
      if (junk && n == 3) begin
        warn_thresh = w0; crit_thresh = c0; hyst = h0;
      end
      if (sample_stb === 1'b1 || n >= 20) break;
    end
    vectors++;
    if (n != exp_gap) begin
      errors++;
      $display("FAIL stb_gap: got %0d clocks want %0d", n, exp_gap);
      return;
    end
    hist.push_back(v);
    if (hist.size() > WIN) void'(hist.pop_front());
    m_count++;
    exp_avg   = window_avg();
    exp_valid = (m_count >= WIN);
    vectors++;
    if (avg_c !== 8'(exp_avg) || avg_valid !== exp_valid) begin
      errors++;
      $display("FAIL avg: got avg=%0d valid=%0b want avg=%0d valid=%0b", avg_c, avg_valid, exp_avg, exp_valid);
    end
    if (exp_valid) begin
      tgt = target_of(m_state, exp_avg, warn_thresh, crit_thresh, hyst);
      if (tgt == m_state) run_len = 0;
      else if (run_len > 0 && tgt == run_tgt) run_len++;
      else begin run_len = 1; run_tgt = tgt; end
      if (run_len == PERSIST) begin m_state = tgt; run_len = 0; end
    end
    @(negedge clk);
    vectors++;
    if (sample_stb !== 1'b0 || state !== 2'(m_state) || warn !== (m_state != 0) || crit !== (m_state == 2)) begin
      errors++;
      $display("FAIL state: got stb=%0b st=%0d warn=%0b crit=%0b want stb=0 st=%0d warn=%0b crit=%0b (sample %0d avg %0d)",
               sample_stb, state, warn, crit, m_state, m_state != 0, m_state == 2, v, exp_avg);
    end
    if (m_state == 2) m_latch = 1'b1;
    $display("sample %3d avg %3d valid %0b state %0d", v, exp_avg, exp_valid, m_state);
  endtask

  task automatic apply_list(input int v, input int reps);
    for (int i = 0; i < reps; i++) apply_sample(v, 4, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    logic z;
    z = (sample_stb === 1'b0) && (avg_c === 8'd0) && (avg_valid === 1'b0) &&
        (state === 2'd0) && (warn === 1'b0) && (crit === 1'b0);
`ifdef TEMP_MON_CRIT_LATCH_EN
    z = z && (crit_latched === 1'b0);
`endif
    vectors++;
    if (!z) begin
      errors++;
      $display("FAIL %s: got stb=%0b avg=%0d valid=%0b st=%0d warn=%0b crit=%0b want all 0",
               tag, sample_stb, avg_c, avg_valid, state, warn, crit);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    celsius = 8'd37;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rstn = 1'b1;
    model_reset();
    apply_sample(37, SAMPLE_DIV + 1, 1'b0, 1'b0);
    apply_list(37, 3);
  endtask

  task automatic test_average();
    apply_list(60, 1); apply_list(70, 1); apply_list(80, 1); apply_list(90, 1);
    apply_list(37, 3); apply_list(38, 1);
  endtask

  task automatic test_fsm();
    apply_list(75, 6); apply_list(60, 2);
    apply_list(75, 6); apply_list(66, 6); apply_list(64, 6);
    apply_list(95, 6); apply_list(87, 6); apply_list(80, 6);
  endtask

  task automatic test_latch();
    apply_sample(80, 4, 1'b0, 1'b1);
    apply_list(95, 6);
    apply_sample(95, 4, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    apply_sample(95, SAMPLE_DIV + 1, 1'b0, 1'b0);
    apply_list(95, 6);
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 7; blk++) begin
      if (blk == 5) begin
        warn_thresh = 8'd3; crit_thresh = 8'd8; hyst = 8'd10;
      end else if (blk == 6) begin
        warn_thresh = 8'd80; crit_thresh = 8'd60; hyst = 8'd4;
      end else begin
        warn_thresh = 8'($urandom_range(40, 90));
        crit_thresh = 8'($urandom_range(40, 110));
        hyst        = 8'($urandom_range(0, 20));
      end
      for (int i = 0; i < 20; i++) begin
        int v;
        v = (blk == 5) ? $urandom_range(0, 15) : $urandom_range(30, 120);
        apply_sample(v, 4, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_average();
    test_fsm();
    test_latch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
